// File: rtl/mul8_fsm.sv
// mul8_fsm -- sequential 8x8 unsigned shift-and-add multiplier-accumulator.
//
// Computes P = A*B + C (or P = A*B when MUL_ACC_EN is not defined), one
// partial product per clock, behind a start/busy/done handshake. It rebuilds
// a dividend from quotient (A), divisor (B) and remainder (C) for the
// companion 8-bit divider.
//
// Build option:
//   MUL_ACC_EN  defined   -> accumulator starts at {8'b0, C}
//               undefined -> accumulator starts at 0; the C port is ignored
//
// Ports:
//   clk    in   1   system clock, rising edge
//   rst    in   1   synchronous, active-high reset (priority over start)
//   start  in   1   operation request, sampled only in IDLE
//   A      in   8   multiplicand, captured on the accepting edge
//   B      in   8   multiplier, captured on the accepting edge
//   C      in   8   addend, captured on the accepting edge
//   P      out  16  result register, holds until the next operation completes
//   busy   out  1   high in CALC and DONE
//   done   out  1   one-cycle pulse in DONE
module mul8_fsm (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [7:0]  A,
    input  logic [7:0]  B,
    input  logic [7:0]  C,
    output logic [15:0] P,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [15:0] acc_q,   acc_d;
    logic [15:0] mcand_q, mcand_d;
    logic [7:0]  mplier_q, mplier_d;
    logic [2:0]  cnt_q,   cnt_d;
    logic [15:0] p_q,     p_d;

    logic [15:0] acc_load;
    logic [15:0] sum;

`ifdef MUL_ACC_EN
    assign acc_load = {8'b0, C};
`else
    assign acc_load = '0;
    // C is deliberately unconnected in this build; this reduction drives nothing.
    logic unused_c;
    assign unused_c = ^C;
`endif

    // Accumulator after this step's conditional add; also the final result
    // when the eighth partial product is taken.
    assign sum = acc_q + (mplier_q[0] ? mcand_q : 16'h0000);

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        mplier_d = mplier_q;
        cnt_d    = cnt_q;
        p_d      = p_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    mcand_d  = {8'b0, A};
                    mplier_d = B;
                    acc_d    = acc_load;
                    cnt_d    = '0;
                    state_d  = S_CALC;
                end
            end
            S_CALC: begin
                acc_d    = sum;
                mcand_d  = mcand_q << 1;
                mplier_d = mplier_q >> 1;
                cnt_d    = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    p_d     = sum;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
            cnt_q    <= '0;
            p_q      <= '0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            mplier_q <= mplier_d;
            cnt_q    <= cnt_d;
            p_q      <= p_d;
        end
    end

    assign P    = p_q;
    assign busy = (state_q != S_IDLE);
    assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_mul8_fsm.sv
// tb_mul8_fsm -- self-checking bench for mul8_fsm.
// Expected results come from plain integer arithmetic (A*B [+ C]); the
// handshake is checked cycle by cycle against the documented timing.
module tb_mul8_fsm;

`ifdef MUL_ACC_EN
    localparam bit ACC_EN = 1'b1;
`else
    localparam bit ACC_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  A = '0;
    logic [7:0]  B = '0;
    logic [7:0]  C = '0;
    logic [15:0] P;
    logic        busy;
    logic        done;

    int unsigned checks = 0;
    int unsigned failures = 0;
    logic [15:0] exp_p = '0;

    mul8_fsm dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .C     (C),
        .P     (P),
        .busy  (busy),
        .done  (done)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b,
                                          input logic [7:0] c);
        int r;
        r = int'(a) * int'(b) + (ACC_EN ? int'(c) : 0);
        return r[15:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Called at a negedge while IDLE: present operands, let the next edge
    // accept them, then drop start.
    task automatic launch(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        A = a; B = b; C = c; start = 1'b1;
        exp_p = model(a, b, c);
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Follows one operation from the accepting edge through the IDLE cycle
    // after DONE. With disturb set, operands are scrambled and start is
    // raised during CALC and DONE; neither may affect the result.
    task automatic track(input bit disturb);
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            check("busy_in_op", {31'b0, busy}, 32'd1);
            check("done_timing", {31'b0, done}, {31'b0, (k == 9)});
            if (k == 9) check("p_at_done", {16'b0, P}, {16'b0, exp_p});
            if (disturb) begin
                A = 8'($urandom); B = 8'($urandom); C = 8'($urandom);
                start = (k >= 1);
            end
        end
        @(negedge clk);
        check("idle_busy", {31'b0, busy}, 32'd0);
        check("idle_done", {31'b0, done}, 32'd0);
        check("p_hold", {16'b0, P}, {16'b0, exp_p});
        start = 1'b0;
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_p", {16'b0, P}, 32'h0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_busy", {31'b0, busy}, 32'd0);

        // Divider round-trip case
        launch(8'd7, 8'd21, 8'd17);
        track(1'b0);
        check("case_7x21", {16'b0, P}, ACC_EN ? 32'd164 : 32'd147);

        // Maximum operands, no wrap
        launch(8'd255, 8'd255, 8'd255);
        track(1'b0);
        check("case_max", {16'b0, P}, ACC_EN ? 32'd65280 : 32'd65025);

        // Zero multiplicand / zero multiplier, timing unchanged
        launch(8'd0, 8'd200, 8'd5);
        track(1'b0);
        check("case_a0", {16'b0, P}, ACC_EN ? 32'd5 : 32'd0);
        launch(8'd200, 8'd0, 8'd0);
        track(1'b0);
        check("case_b0", {16'b0, P}, 32'd0);

        // start and operand churn during the operation, then a start in
        // the cycle right after done
        launch(8'd7, 8'd21, 8'd17);
        track(1'b1);
        launch(8'd13, 8'd11, 8'd9);
        track(1'b0);

        // Reset sampled at CALC edge 4 abandons the operation
        launch(8'd99, 8'd77, 8'd55);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_p", {16'b0, P}, 32'h0);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_done", {31'b0, done}, 32'd0);
        rst = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            check("midrst_no_done", {30'b0, busy, done}, 32'd0);
        end
        launch(8'd12, 8'd12, 8'd0);
        track(1'b0);
        check("case_12x12", {16'b0, P}, 32'd144);

        // start held high: one operation every 10 cycles
        A = 8'd3; B = 8'd5; C = 8'd1;
        exp_p = model(8'd3, 8'd5, 8'd1);
        start = 1'b1;
        for (int k = 1; k <= 29; k++) begin
            @(negedge clk);
            check("held_done", {31'b0, done}, {31'b0, (k % 10 == 9)});
            check("held_busy", {31'b0, busy}, {31'b0, (k % 10 != 0)});
            if (k % 10 == 9) check("held_p", {16'b0, P}, {16'b0, exp_p});
        end
        start = 1'b0;
        @(negedge clk);
        check("held_end_idle", {31'b0, busy}, 32'd0);

        // Randomized operations against the arithmetic model
        for (int n = 0; n < 16; n++) begin
            launch(8'($urandom), 8'($urandom), 8'($urandom));
            track(1'($urandom_range(0, 1)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
